// File: rtl/crc_frame_seq_if.sv
// Frame/result handshake bundle for crc_frame_seq.
// master: packet source plus checksum consumer. slave: the sequencer.
interface crc_frame_seq_if #(
   parameter int DATA_WIDTH      = 8,
   parameter int POLYNOMIAL_BITS = 8,
   parameter int CNT_WIDTH       = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [DATA_WIDTH-1:0]      in_data;
   logic                       in_sop;
   logic                       in_eop;
   logic                       crc_valid;
   logic                       crc_ready;
   logic [POLYNOMIAL_BITS-1:0] crc_val;
   logic [CNT_WIDTH-1:0]       frame_len;
   logic                       err_sop;

   modport master (
      output in_valid, in_data, in_sop, in_eop, crc_ready,
      input  in_ready, crc_valid, crc_val, frame_len, err_sop
   );

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, crc_ready,
      output in_ready, crc_valid, crc_val, frame_len, err_sop
   );
endinterface

// File: rtl/crc_frame_seq.sv
// Frame-level CRC sequencer: folds a multi-beat frame into one CRC and
// beat count, then holds the result on a back-pressured result handshake.
// The interface instance must carry the same parameters as this module.
module crc_frame_seq #(
   parameter int DATA_WIDTH      = 8,
   parameter int POLYNOMIAL_BITS = 8,
   parameter int CNT_WIDTH       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   crc_frame_seq_if.slave    bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam bit POLY_LEGAL =
      (POLYNOMIAL_BITS == 1)  || (POLYNOMIAL_BITS == 4)  || (POLYNOMIAL_BITS == 5)  ||
      (POLYNOMIAL_BITS == 6)  || (POLYNOMIAL_BITS == 7)  || (POLYNOMIAL_BITS == 8)  ||
      (POLYNOMIAL_BITS == 10) || (POLYNOMIAL_BITS == 12) || (POLYNOMIAL_BITS == 15) ||
      (POLYNOMIAL_BITS == 16) || (POLYNOMIAL_BITS == 24) || (POLYNOMIAL_BITS == 32);

   // Generator coefficients without the implicit x^N term.
   localparam logic [31:0] POLY_FULL =
      (POLYNOMIAL_BITS == 1)  ? 32'h0000_0001 :
      (POLYNOMIAL_BITS == 4)  ? 32'h0000_0003 :
      (POLYNOMIAL_BITS == 5)  ? 32'h0000_0005 :
      (POLYNOMIAL_BITS == 6)  ? 32'h0000_0007 :
      (POLYNOMIAL_BITS == 7)  ? 32'h0000_0009 :
      (POLYNOMIAL_BITS == 8)  ? 32'h0000_009B :
      (POLYNOMIAL_BITS == 10) ? 32'h0000_0233 :
      (POLYNOMIAL_BITS == 12) ? 32'h0000_080F :
      (POLYNOMIAL_BITS == 15) ? 32'h0000_4599 :
      (POLYNOMIAL_BITS == 16) ? 32'h0000_8005 :
      (POLYNOMIAL_BITS == 24) ? 32'h00FF_FA09 :
      (POLYNOMIAL_BITS == 32) ? 32'h04C1_1DB7 : 32'h0000_0000;

   localparam logic [POLYNOMIAL_BITS-1:0] POLY = POLY_FULL[POLYNOMIAL_BITS-1:0];

   if (!POLY_LEGAL) begin : g_bad_poly
      $error("crc_frame_seq: unsupported POLYNOMIAL_BITS = %0d", POLYNOMIAL_BITS);
   end

   // One full beat through the serial CRC recurrence, MSB first; the shift
   // form keeps the width at POLYNOMIAL_BITS so a 1-bit CRC also works.
   function automatic logic [POLYNOMIAL_BITS-1:0] crc_step(
      input logic [POLYNOMIAL_BITS-1:0] crc_in,
      input logic [DATA_WIDTH-1:0]      data
   );
      logic [POLYNOMIAL_BITS-1:0] c;
      logic                       fb;
      c = crc_in;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         fb = data[i] ^ c[POLYNOMIAL_BITS-1];
         c  = (c << 1) ^ ({POLYNOMIAL_BITS{fb}} & POLY);
      end
      return c;
   endfunction

   logic [1:0]                 state_q,   state_d;
   logic [POLYNOMIAL_BITS-1:0] crc_acc_q, crc_acc_d;
   logic [CNT_WIDTH-1:0]       cnt_q,     cnt_d;
   logic                       err_sop_q, err_sop_d;
   logic                       accept;

   // The accumulator and counter cannot change in DONE (no beat is
   // accepted), so they double as the held result registers.
   assign bus.in_ready  = (state_q != ST_DONE);
   assign bus.crc_valid = (state_q == ST_DONE);
   assign bus.crc_val   = crc_acc_q;
   assign bus.frame_len = cnt_q;
   assign bus.err_sop   = err_sop_q;

   assign accept = bus.in_valid && (state_q != ST_DONE);

   // Next-state, accumulator and protocol-error decode.
   always_comb begin
      state_d   = state_q;
      crc_acc_d = crc_acc_q;
      cnt_d     = cnt_q;
      err_sop_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               if (bus.in_sop) begin
                  // A sop inside a frame discards the partial frame.
                  err_sop_d = (state_q == ST_ACCUM);
                  crc_acc_d = crc_step('0, bus.in_data);
                  cnt_d     = CNT_WIDTH'(1);
                  state_d   = bus.in_eop ? ST_DONE : ST_ACCUM;
               end else if (state_q == ST_IDLE) begin
                  // Orphan beat outside a frame: dropped.
                  err_sop_d = 1'b1;
               end else begin
                  crc_acc_d = crc_step(crc_acc_q, bus.in_data);
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + CNT_WIDTH'(1);
                  end
                  if (bus.in_eop) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            if (bus.crc_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         crc_acc_q <= '0;
         cnt_q     <= '0;
         err_sop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_acc_q <= crc_acc_d;
         cnt_q     <= cnt_d;
         err_sop_q <= err_sop_d;
      end
   end

endmodule

// File: tb/tb_crc_frame_seq.sv
// Bench for crc_frame_seq: four instances (CRC-32, CRC-16, CRC-8 and CRC-32
// with a 3-bit counter) share one stimulus stream and are compared each
// cycle against a frame-level reference model.
module tb_crc_frame_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_sop;
   logic       in_eop;
   logic       crc_ready;

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_ready_en = 1'b0;

   always #5 clk = ~clk;

   crc_frame_seq_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(32), .CNT_WIDTH(16)) if32 ();
   crc_frame_seq_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(16), .CNT_WIDTH(16)) if16 ();
   crc_frame_seq_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8),  .CNT_WIDTH(16)) if8  ();
   crc_frame_seq_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(32), .CNT_WIDTH(3))  ifs  ();

   assign if32.in_valid = in_valid;  assign if32.in_data = in_data;
   assign if32.in_sop   = in_sop;    assign if32.in_eop  = in_eop;
   assign if32.crc_ready = crc_ready;
   assign if16.in_valid = in_valid;  assign if16.in_data = in_data;
   assign if16.in_sop   = in_sop;    assign if16.in_eop  = in_eop;
   assign if16.crc_ready = crc_ready;
   assign if8.in_valid  = in_valid;  assign if8.in_data  = in_data;
   assign if8.in_sop    = in_sop;    assign if8.in_eop   = in_eop;
   assign if8.crc_ready = crc_ready;
   assign ifs.in_valid  = in_valid;  assign ifs.in_data  = in_data;
   assign ifs.in_sop    = in_sop;    assign ifs.in_eop   = in_eop;
   assign ifs.crc_ready = crc_ready;

   crc_frame_seq #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(32), .CNT_WIDTH(16)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(if32));
   crc_frame_seq #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(16), .CNT_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(if16));
   crc_frame_seq #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8),  .CNT_WIDTH(16)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8));
   crc_frame_seq #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(32), .CNT_WIDTH(3))  duts (
      .clk(clk), .rst_n(rst_n), .bus(ifs));

   // ---------------- reference model ----------------
   bit          m_done;      // a finished result is waiting for the consumer
   bit          m_in_frame;  // a frame has started and not yet ended
   bit          m_err;       // err_sop expected in the current cycle
   byte unsigned m_bytes[$]; // beats of the current/last frame
   logic [31:0] m_crc32, m_crc16, m_crc8;
   int          m_len;

   function automatic logic [31:0] ref_crc(input int width, input logic [31:0] poly,
                                           input byte unsigned data[$]);
      logic [63:0] c;
      logic [63:0] mask;
      bit          d;
      c    = 64'd0;
      mask = (64'd1 << width) - 64'd1;
      foreach (data[k]) begin
         for (int b = 7; b >= 0; b--) begin
            d = data[k][b] ^ c[width-1];
            c = (c << 1) & mask;
            if (d) c = c ^ {32'h0, poly};
         end
      end
      return c[31:0];
   endfunction

   task automatic model_step();
      bit nerr;
      bit take;
      nerr = 1'b0;
      take = 1'b0;
      if (m_done) begin
         if (crc_ready) m_done = 1'b0;
      end else if (in_valid) begin
         if (in_sop) begin
            nerr = m_in_frame;
            m_bytes.delete();
            m_bytes.push_back(in_data);
            take = 1'b1;
         end else if (!m_in_frame) begin
            nerr = 1'b1;
         end else begin
            m_bytes.push_back(in_data);
            take = 1'b1;
         end
         if (take) begin
            if (in_eop) begin
               m_done     = 1'b1;
               m_in_frame = 1'b0;
               m_crc32    = ref_crc(32, 32'h04C11DB7, m_bytes);
               m_crc16    = ref_crc(16, 32'h00008005, m_bytes);
               m_crc8     = ref_crc(8,  32'h0000009B, m_bytes);
               m_len      = m_bytes.size();
            end else begin
               m_in_frame = 1'b1;
            end
         end
      end
      m_err = nerr;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_done = 1'b0; m_in_frame = 1'b0; m_err = 1'b0;
            m_bytes.delete();
         end else begin
            model_step();
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string tag, input logic rdy, input logic vld, input logic err,
                            input logic [31:0] crc, input logic [15:0] len,
                            input logic [31:0] ecrc, input int sat);
      int elen;
      elen = (m_len > sat) ? sat : m_len;
      chk({tag, ".in_ready"},  rdy, !m_done);
      chk({tag, ".crc_valid"}, vld, m_done);
      chk({tag, ".err_sop"},   err, m_err);
      if (m_done) begin
         chk({tag, ".crc_val"},   crc, ecrc);
         chk({tag, ".frame_len"}, len, elen);
      end else begin
         chk({tag, ".crc_known"}, $isunknown({crc, len}), 0);
      end
   endtask

   // Cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check_dut("c32", if32.in_ready, if32.crc_valid, if32.err_sop,
                      if32.crc_val, if32.frame_len, m_crc32, 65535);
            check_dut("c16", if16.in_ready, if16.crc_valid, if16.err_sop,
                      {16'h0, if16.crc_val}, if16.frame_len, m_crc16, 65535);
            check_dut("c8", if8.in_ready, if8.crc_valid, if8.err_sop,
                      {24'h0, if8.crc_val}, if8.frame_len, m_crc8, 65535);
            check_dut("sat", ifs.in_ready, ifs.crc_valid, ifs.err_sop,
                      ifs.crc_val, {13'h0, ifs.frame_len}, m_crc32, 7);
         end
      end
   end

   // Random consumer backpressure for the random phase.
   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready_en) crc_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_idle(input int n);
      repeat (n) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         in_sop   = 1'($urandom);
         in_eop   = 1'($urandom);
         @(negedge clk);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_beat(input byte unsigned d, input bit s, input bit e);
      int guard;
      guard = 0;
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
      while (!if32.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_checks++; n_fail++;
         $display("FAIL send_beat_timeout: in_ready stayed 0, required 1");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic consume();
      crc_ready = 1'b1;
      @(negedge clk);
      crc_ready = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".rst_in_ready"},  {if32.in_ready, if16.in_ready, if8.in_ready, ifs.in_ready}, 4'hF);
      chk({tag, ".rst_crc_valid"}, {if32.crc_valid, if16.crc_valid, if8.crc_valid, ifs.crc_valid}, 4'h0);
      chk({tag, ".rst_err_sop"},   {if32.err_sop, if16.err_sop, if8.err_sop, ifs.err_sop}, 4'h0);
      chk({tag, ".rst_crc_val"},   {if32.crc_val, if16.crc_val, if8.crc_val}, 0);
      chk({tag, ".rst_frame_len"}, {if32.frame_len, ifs.frame_len}, 0);
   endtask

   byte unsigned digits[$];
   byte unsigned rnd[$];

   // ---------------- main sequence ----------------
   initial begin
      in_valid = 1'b0; in_data = 8'h00; in_sop = 1'b0; in_eop = 1'b0; crc_ready = 1'b0;
      for (int i = 0; i < 9; i++) digits.push_back(8'(8'h31 + i));

      #1 rst_n = 1'b0;
      #1 check_reset_vals("por");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // CRC-32 check value, back-to-back beats
      foreach (digits[i]) send_beat(digits[i], i == 0, i == 8);
      chk("t1_valid", if32.crc_valid, 1);
      chk("t1_crc32", if32.crc_val, 32'h89A1897F);
      chk("t1_len", if32.frame_len, 9);
      chk("t1_crc16", if16.crc_val, 16'hFEE8);
      chk("t1_sat_len", ifs.frame_len, 7);
      chk("t1_model32", m_crc32, 32'h89A1897F);
      $display("frame check32: crc=0x%08h len=%0d", if32.crc_val, if32.frame_len);
      consume();

      // CRC-16 check value with random in_valid gaps
      foreach (digits[i]) begin
         drive_idle($urandom_range(0, 3));
         send_beat(digits[i], i == 0, i == 8);
      end
      chk("t2_crc16", if16.crc_val, 16'hFEE8);
      chk("t2_len", if16.frame_len, 9);
      chk("t2_model16", m_crc16, 32'h0000FEE8);
      $display("frame check16: crc=0x%04h len=%0d", if16.crc_val, if16.frame_len);
      consume();

      // Single-beat frame held under backpressure, second frame offered
      send_beat(8'h01, 1'b1, 1'b1);
      chk("t3_crc8", if8.crc_val, 8'h9B);
      chk("t3_len", if8.frame_len, 1);
      chk("t3_model8", m_crc8, 32'h9B);
      in_valid = 1'b1; in_data = 8'h00; in_sop = 1'b1; in_eop = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t3_stall_ready", if8.in_ready, 0);
         chk("t3_stall_crc", if8.crc_val, 8'h9B);
      end
      crc_ready = 1'b1;
      @(negedge clk);
      crc_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t3_second_valid", if8.crc_valid, 1);
      chk("t3_second_crc8", if8.crc_val, 8'h00);
      $display("frame single: crc8=0x%02h len=%0d", if8.crc_val, if8.frame_len);
      consume();

      // Protocol errors
      crc_ready = 1'b1;
      send_beat(8'h55, 1'b0, 1'b0);
      chk("t4_orphan_err", if32.err_sop, 1);
      @(negedge clk);
      chk("t4_orphan_err_clr", if32.err_sop, 0);
      chk("t4_orphan_novalid", if32.crc_valid, 0);
      send_beat(8'h41, 1'b1, 1'b0);
      send_beat(8'h42, 1'b0, 1'b0);
      foreach (digits[i]) begin
         send_beat(digits[i], i == 0, i == 8);
         if (i == 0) chk("t4_restart_err", if32.err_sop, 1);
      end
      chk("t4_restart_crc32", if32.crc_val, 32'h89A1897F);
      chk("t4_restart_len", if32.frame_len, 9);
      $display("frame restart: crc=0x%08h len=%0d", if32.crc_val, if32.frame_len);
      @(negedge clk);
      crc_ready = 1'b0;

      // Reset mid-frame and in DONE
      for (int i = 0; i < 4; i++) send_beat(8'($urandom), i == 0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midframe");
      @(negedge clk);
      rst_n = 1'b1;
      send_beat(8'h07, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(8'($urandom), i == 0, i == 2);
      chk("t5_done_before_rst", if32.crc_valid, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("indone");
      @(negedge clk);
      rst_n = 1'b1;
      foreach (digits[i]) send_beat(digits[i], i == 0, i == 8);
      chk("t5_clean_crc32", if32.crc_val, 32'h89A1897F);
      $display("frame after reset: crc=0x%08h len=%0d", if32.crc_val, if32.frame_len);
      consume();

      // Counter saturation: 10-beat frame
      for (int i = 0; i < 10; i++) send_beat(8'($urandom), i == 0, i == 9);
      chk("t6_sat_len", ifs.frame_len, 7);
      chk("t6_full_len", if32.frame_len, 10);
      $display("frame saturate: len3=%0d len16=%0d", ifs.frame_len, if32.frame_len);
      consume();

      // Random frames, gaps, stray/missing sop, random consumer readiness
      rand_ready_en = 1'b1;
      for (int f = 0; f < 60; f++) begin
         int len;
         bit s;
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            drive_idle($urandom_range(0, 2));
            s = (j == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            send_beat(8'($urandom), s, j == len - 1);
         end
         $display("random frame %0d: beats=%0d model_len=%0d model_crc32=0x%08h",
                  f, len, m_len, m_crc32);
      end
      rand_ready_en = 1'b0;
      @(negedge clk);
      crc_ready = 1'b1;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
